ysyx_24090003_ifu_prefetch: RTL and testbench

YSYX_24090003_IFU_PREFETCH -- requirements
Module: ysyx_24090003_ifu_prefetch

---
 rtl/ysyx_24090003_ifu_prefetch.sv | 121 ++++++++++++
 tb/tb_ysyx_24090003_ifu_prefetch.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ysyx_24090003_ifu_prefetch.sv
// Instruction prefetch unit: issues one fetch at a time to instruction memory,
// buffers returned instructions with their PCs in a small FIFO for decode,
// and discards in-flight responses when EX redirects the fetch stream.
module ysyx_24090003_ifu_prefetch #(
   parameter int             XLEN     = 32,
   parameter int             ILEN     = 32,
   parameter int             DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h80000000)
) (
   input  logic            cpu_clk,
   input  logic            cpu_rs,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [ILEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [ILEN-1:0] out_inst
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_FLUSH} state_e;

   state_e          state_q;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] req_pc_q;
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic [XLEN-1:0] pc_mem   [DEPTH];
   logic [ILEN-1:0] inst_mem [DEPTH];

   logic accept, push, pop;
   logic unused_lsb;

   // Redirect targets are word aligned; the low bits are dropped.
   assign unused_lsb = ^redirect_pc[1:0];

   // A request is only offered while a FIFO slot is free, so every response has room.
   assign imem_req_valid = !cpu_rs && (state_q == S_REQ) && (count_q < CW'(DEPTH));
   assign imem_req_addr  = fetch_pc_q;
   assign accept         = imem_req_valid & imem_req_ready;
   assign push           = (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;
   assign pop            = out_valid && out_ready && !redirect_valid;

   assign out_valid = (count_q != '0);
   assign out_pc    = out_valid ? pc_mem[rd_ptr_q]   : '0;
   assign out_inst  = out_valid ? inst_mem[rd_ptr_q] : '0;

   // Next fetch PC: redirect wins over sequential advance.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (redirect_valid)
         fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      else if (accept)
         fetch_pc_d = fetch_pc_q + XLEN'(4);
   end

   // Fetch FSM: one outstanding request; a redirected request drains through S_FLUSH.
   always_ff @(posedge cpu_clk or posedge cpu_rs) begin
      if (cpu_rs) begin
         state_q    <= S_REQ;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         case (state_q)
            S_REQ: begin
               if (accept) begin
                  req_pc_q <= fetch_pc_q;
                  state_q  <= redirect_valid ? S_FLUSH : S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid)      state_q <= S_REQ;
               else if (redirect_valid) state_q <= S_FLUSH;
            end
            S_FLUSH: begin
               if (imem_rsp_valid) state_q <= S_REQ;
            end
            default: state_q <= S_REQ;
         endcase
      end
   end

   // Occupancy: simultaneous push and pop leave the count unchanged.
   always_comb begin
      count_d = count_q + CW'(push) - CW'(pop);
   end

   // FIFO pointers and count; redirect empties the buffer.
   always_ff @(posedge cpu_clk or posedge cpu_rs) begin
      if (cpu_rs) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (redirect_valid) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   // Entry storage; contents are only observed while counted as valid.
   always_ff @(posedge cpu_clk) begin
      if (push) begin
         pc_mem[wr_ptr_q]   <= req_pc_q;
         inst_mem[wr_ptr_q] <= imem_rsp_data;
      end
   end

endmodule

// File: tb/tb_ysyx_24090003_ifu_prefetch.sv
// Randomized bench for the prefetch unit: a random-latency memory, random
// redirects, back-pressure and resets, checked against a queue-based model.
module tb_ysyx_24090003_ifu_prefetch;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h80000000;
   localparam int          NCYC     = 6000;

   logic        cpu_clk, cpu_rs;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid, out_ready;
   logic [31:0] out_pc, out_inst;

   ysyx_24090003_ifu_prefetch #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .cpu_clk(cpu_clk), .cpu_rs(cpu_rs),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_inst(out_inst)
   );

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'hC3A50F1E;
   endfunction

   // Reference model: the buffer is a queue of {pc, inst}; "pend" means a
   // request has been accepted and its response not yet seen, "drop" means
   // that response belongs to an abandoned stream.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t        q[$];
   bit          pend, drop;
   logic [31:0] fpc, rpc;

   // Memory side of the bench
   bit          mem_busy;
   logic [31:0] mem_addr;
   int          mem_lat;

   task automatic model_reset();
      q.delete();
      pend = 0;
      drop = 0;
      fpc  = RESET_PC;
      rpc  = '0;
   endtask

   initial begin
      bit          e_rv, acc, do_pop;
      int          rs_cnt, p_ordy, p_redir;
      ent_t        e;
      logic [31:0] t;

      cpu_rs = 1'b1;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      model_reset();
      mem_busy = 0; mem_addr = '0; mem_lat = 0;
      rs_cnt = 3; p_ordy = 2; p_redir = 12;

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge cpu_clk);
         // ---- compare outputs against the model
         e_rv = !cpu_rs && !pend && (q.size() < DEPTH);
         chk("req_valid", 64'(imem_req_valid), 64'(e_rv));
         if (e_rv || cpu_rs) chk("req_addr", 64'(imem_req_addr), 64'(fpc));
         chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
         chk("out_pc",   64'(out_pc),   64'((q.size() != 0) ? q[0].pc   : 32'h0));
         chk("out_inst", 64'(out_inst), 64'((q.size() != 0) ? q[0].inst : 32'h0));

         // ---- traffic phase: vary back-pressure and redirect rate
         if (cyc % 300 == 0) begin
            p_ordy  = $urandom_range(0, 3);
            p_redir = $urandom_range(6, 40);
         end

         // ---- reset (asynchronous, applied at once)
         if (rs_cnt == 0 && cyc > 10 && ($urandom % 250) == 0) rs_cnt = $urandom_range(1, 2);
         cpu_rs = (rs_cnt != 0);
         if (rs_cnt != 0) rs_cnt--;
         if (cpu_rs) model_reset();

         // ---- memory response (possibly stale after reset, or spurious when idle)
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
         if (mem_busy) begin
            if (mem_lat == 0) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = mdata(mem_addr);
               mem_busy = 0;
            end else mem_lat--;
         end else if (($urandom % 16) == 0) imem_rsp_valid = 1'b1;

         imem_req_ready = !mem_busy && (($urandom % 4) != 0);

         // ---- redirect, sometimes near the top of the address space to wrap
         redirect_valid = (($urandom % p_redir) == 0);
         t = $urandom;
         case ($urandom % 4)
            0: redirect_pc = 32'hFFFFFFF0 | (t & 32'hF);
            1: redirect_pc = 32'h80001000 | (t & 32'h3F);
            default: redirect_pc = t;
         endcase

         out_ready = ($urandom_range(0, 3) < p_ordy) || (p_ordy == 3);

         // ---- advance model through the coming rising edge
         e_rv = !cpu_rs && !pend && (q.size() < DEPTH);
         acc  = e_rv && imem_req_ready;
         if (acc) begin
            mem_busy = 1;
            mem_addr = fpc;
            mem_lat  = $urandom_range(0, 2);
         end
         if (!cpu_rs) begin
            do_pop = (q.size() != 0) && out_ready && !redirect_valid;
            if (do_pop) void'(q.pop_front());
            if (pend && imem_rsp_valid) begin
               if (!drop && !redirect_valid) begin
                  e.pc = rpc; e.inst = imem_rsp_data;
                  q.push_back(e);
               end
               pend = 0;
               drop = 0;
            end else if (pend && redirect_valid) drop = 1;
            if (acc) begin
               rpc  = fpc;
               pend = 1;
               drop = redirect_valid;
               fpc  = fpc + 32'd4;
            end
            if (redirect_valid) begin
               q.delete();
               fpc = {redirect_pc[31:2], 2'b00};
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
